// File: rtl/sized_fifo_pkg.sv
// sized_fifo shared helpers.
// Pointer stepping that wraps on entry count, not on pointer width.
package sized_fifo_pkg;

   function automatic int unsigned ptr_next(
      input int unsigned ptr,
      input int unsigned entries
   );
      return (ptr + 1 >= entries) ? 0 : ptr + 1;
   endfunction

endpackage

// File: rtl/sized_fifo_if.sv
// sized_fifo enqueue/dequeue bus.
// master drives requests, slave is the FIFO.
interface sized_fifo_if #(
   parameter int p1width = 16
);
   logic [p1width-1:0] D_IN;
   logic               ENQ;
   logic               FULL_N;
   logic [p1width-1:0] D_OUT;
   logic               DEQ;
   logic               EMPTY_N;
   logic               CLR;

   modport master (
      output D_IN, ENQ, DEQ, CLR,
      input  D_OUT, FULL_N, EMPTY_N
   );

   modport slave (
      input  D_IN, ENQ, DEQ, CLR,
      output D_OUT, FULL_N, EMPTY_N
   );
endinterface

// File: rtl/sized_fifo_mem.sv
// sized_fifo backing buffer.
// One write port, one asynchronous read port.
module sized_fifo_mem #(
   parameter int p1width = 16,
   parameter int entries = 2,
   parameter int aw      = 1
) (
   input  logic               clk,
   input  logic               we,
   input  logic [aw-1:0]      waddr,
   input  logic [p1width-1:0] wdata,
   input  logic [aw-1:0]      raddr,
   output logic [p1width-1:0] rdata
);
   logic [p1width-1:0] mem_q [entries];

   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[waddr] <= wdata;
      end
   end

   assign rdata = mem_q[raddr];
endmodule

// File: rtl/sized_fifo.sv
// sized_fifo: head register plus circular buffer.
// Registered flags and head; capacity p2depth.
module sized_fifo
   import sized_fifo_pkg::*;
#(
   parameter int p1width      = 16,
   parameter int p2depth      = 3,
   parameter int p3cntr_width = 1
) (
   input logic         CLK,
   input logic         RST,
   sized_fifo_if.slave fifo_s
);
   localparam int CW = $clog2(p2depth + 1);
   localparam int BD = p2depth - 1;
   localparam int PW = p3cntr_width;

   logic [CW-1:0]      count_q, count_d;
   logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
   logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
   logic               empty_n_q, empty_n_d;
   logic               full_n_q, full_n_d;
   logic [p1width-1:0] head_q, head_d;
   logic               mem_we;
   logic [p1width-1:0] mem_rdata;
   logic               enq_ok;
   logic               deq_ok;
   logic               head_load;

   assign enq_ok = fifo_s.ENQ & full_n_q;
   assign deq_ok = fifo_s.DEQ & empty_n_q;

   // Incoming data bypasses the buffer when it becomes the head directly.
   assign head_load = enq_ok &
      ((count_q == '0) | (deq_ok & (count_q == CW'(1))));

   sized_fifo_mem #(
      .p1width (p1width),
      .entries (BD),
      .aw      (PW)
   ) u_mem (
      .clk   (CLK),
      .we    (mem_we),
      .waddr (wr_ptr_q),
      .wdata (fifo_s.D_IN),
      .raddr (rd_ptr_q),
      .rdata (mem_rdata)
   );

   always_comb begin
      count_d   = count_q;
      rd_ptr_d  = rd_ptr_q;
      wr_ptr_d  = wr_ptr_q;
      empty_n_d = empty_n_q;
      full_n_d  = full_n_q;
      head_d    = head_q;
      mem_we    = 1'b0;
      if (fifo_s.CLR) begin
         count_d   = '0;
         rd_ptr_d  = '0;
         wr_ptr_d  = '0;
         empty_n_d = 1'b0;
         full_n_d  = 1'b1;
      end else begin
         count_d   = count_q + CW'(enq_ok) - CW'(deq_ok);
         empty_n_d = (count_d != '0);
         full_n_d  = (count_d != CW'(p2depth));
         if (head_load) begin
            head_d = fifo_s.D_IN;
         end else if (enq_ok) begin
            mem_we   = 1'b1;
            wr_ptr_d = PW'(ptr_next(32'(wr_ptr_q), BD));
         end
         if (deq_ok && (count_q >= CW'(2))) begin
            head_d   = mem_rdata;
            rd_ptr_d = PW'(ptr_next(32'(rd_ptr_q), BD));
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (!RST) begin
         count_q   <= '0;
         rd_ptr_q  <= '0;
         wr_ptr_q  <= '0;
         empty_n_q <= 1'b0;
         full_n_q  <= 1'b1;
         head_q    <= '0;
      end else begin
         count_q   <= count_d;
         rd_ptr_q  <= rd_ptr_d;
         wr_ptr_q  <= wr_ptr_d;
         empty_n_q <= empty_n_d;
         full_n_q  <= full_n_d;
         head_q    <= head_d;
      end
   end

   assign fifo_s.D_OUT   = head_q;
   assign fifo_s.EMPTY_N = empty_n_q;
   assign fifo_s.FULL_N  = full_n_q;
endmodule

// File: tb/tb_sized_fifo.sv
// Directed bench for sized_fifo (depth 3, width 16).
// Scenario tasks with inline checks.
module tb_sized_fifo;
   logic clk = 1'b0;
   logic rst = 1'b0;
   int   tests = 0;
   int   fails = 0;

   always #5 clk = ~clk;

   sized_fifo_if #(.p1width(16)) bus ();

   sized_fifo #(
      .p1width      (16),
      .p2depth      (3),
      .p3cntr_width (1)
   ) dut (
      .CLK    (clk),
      .RST    (rst),
      .fifo_s (bus)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic e, input logic d, input logic [15:0] v);
      bus.ENQ  = e;
      bus.DEQ  = d;
      bus.D_IN = v;
   endtask

   task automatic test_reset();
      bus.CLR = 1'b0;
      drive(1'b1, 1'b0, 16'hFFFF);
      rst = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      drive(1'b0, 1'b0, 16'h0);
      tests++;
      if (bus.EMPTY_N !== 1'b0) begin
         fails++; $display("FAIL rst_empty_n got=%b exp=0", bus.EMPTY_N);
      end
      tests++;
      if (bus.FULL_N !== 1'b1) begin
         fails++; $display("FAIL rst_full_n got=%b exp=1", bus.FULL_N);
      end
      tests++;
      if (bus.D_OUT !== 16'h0) begin
         fails++; $display("FAIL rst_d_out got=%h exp=0000", bus.D_OUT);
      end
      tick();
      tests++;
      if (bus.EMPTY_N !== 1'b0 || bus.FULL_N !== 1'b1) begin
         fails++;
         $display("FAIL idle_flags got=%b%b exp=01", bus.EMPTY_N, bus.FULL_N);
      end
   endtask

   task automatic test_fill_drain();
      logic [15:0] vals [3];
      vals[0] = 16'h0001;
      vals[1] = 16'h0002;
      vals[2] = 16'h0003;
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 1'b0, vals[i]);
         tick();
         tests++;
         if (bus.EMPTY_N !== 1'b1 || bus.D_OUT !== 16'h0001) begin
            fails++;
            $display("FAIL fill_head i=%0d got=%b/%h exp=1/0001",
                     i, bus.EMPTY_N, bus.D_OUT);
         end
         tests++;
         if (bus.FULL_N !== (i != 2)) begin
            fails++;
            $display("FAIL fill_full_n i=%0d got=%b exp=%b",
                     i, bus.FULL_N, (i != 2));
         end
      end
      drive(1'b1, 1'b0, 16'hDEAD);
      tick();
      tests++;
      if (bus.FULL_N !== 1'b0 || bus.D_OUT !== 16'h0001) begin
         fails++;
         $display("FAIL enq_when_full got=%b/%h exp=0/0001",
                  bus.FULL_N, bus.D_OUT);
      end
      for (int i = 0; i < 3; i++) begin
         tests++;
         if (bus.D_OUT !== vals[i] || bus.EMPTY_N !== 1'b1) begin
            fails++;
            $display("FAIL drain i=%0d got=%h exp=%h", i, bus.D_OUT, vals[i]);
         end
         drive(1'b0, 1'b1, 16'h0);
         tick();
      end
      drive(1'b0, 1'b0, 16'h0);
      tests++;
      if (bus.EMPTY_N !== 1'b0 || bus.FULL_N !== 1'b1) begin
         fails++;
         $display("FAIL drain_empty got=%b%b exp=01", bus.EMPTY_N, bus.FULL_N);
      end
      tests++;
      if (bus.D_OUT !== 16'h0003) begin
         fails++; $display("FAIL drain_hold got=%h exp=0003", bus.D_OUT);
      end
   endtask

   task automatic test_streaming();
      drive(1'b1, 1'b0, 16'h0010);
      tick();
      for (int i = 1; i <= 8; i++) begin
         drive(1'b1, 1'b1, 16'h0010 + 16'(i));
         tick();
         tests++;
         if (bus.D_OUT !== 16'h0010 + 16'(i) ||
             bus.EMPTY_N !== 1'b1 || bus.FULL_N !== 1'b1) begin
            fails++;
            $display("FAIL stream i=%0d got=%h/%b%b exp=%h/11",
                     i, bus.D_OUT, bus.EMPTY_N, bus.FULL_N, 16'h0010 + 16'(i));
         end
      end
      drive(1'b0, 1'b1, 16'h0);
      tick();
      drive(1'b0, 1'b0, 16'h0);
      tests++;
      if (bus.EMPTY_N !== 1'b0) begin
         fails++; $display("FAIL stream_end got=%b exp=0", bus.EMPTY_N);
      end
   endtask

   task automatic test_full_boundary();
      drive(1'b1, 1'b0, 16'h000A); tick();
      drive(1'b1, 1'b0, 16'h000B); tick();
      drive(1'b1, 1'b0, 16'h000C); tick();
      tests++;
      if (bus.FULL_N !== 1'b0) begin
         fails++; $display("FAIL full_set got=%b exp=0", bus.FULL_N);
      end
      drive(1'b1, 1'b1, 16'h000D);
      tick();
      tests++;
      if (bus.D_OUT !== 16'h000B || bus.FULL_N !== 1'b1) begin
         fails++;
         $display("FAIL full_enq_deq got=%h/%b exp=000b/1", bus.D_OUT, bus.FULL_N);
      end
      drive(1'b0, 1'b1, 16'h0);
      tick();
      tests++;
      if (bus.D_OUT !== 16'h000C || bus.EMPTY_N !== 1'b1) begin
         fails++;
         $display("FAIL full_drain1 got=%h/%b exp=000c/1", bus.D_OUT, bus.EMPTY_N);
      end
      tick();
      drive(1'b0, 1'b0, 16'h0);
      tests++;
      if (bus.EMPTY_N !== 1'b0) begin
         fails++; $display("FAIL full_dropped got=%b exp=0", bus.EMPTY_N);
      end
   endtask

   task automatic test_empty_boundary();
      drive(1'b0, 1'b1, 16'h0);
      tick();
      tests++;
      if (bus.EMPTY_N !== 1'b0 || bus.FULL_N !== 1'b1 ||
          bus.D_OUT !== 16'h000C) begin
         fails++;
         $display("FAIL deq_empty got=%b%b/%h exp=01/000c",
                  bus.EMPTY_N, bus.FULL_N, bus.D_OUT);
      end
      drive(1'b1, 1'b1, 16'h0055);
      tick();
      tests++;
      if (bus.EMPTY_N !== 1'b1 || bus.D_OUT !== 16'h0055) begin
         fails++;
         $display("FAIL empty_enq_deq got=%b/%h exp=1/0055",
                  bus.EMPTY_N, bus.D_OUT);
      end
      drive(1'b0, 1'b1, 16'h0);
      tick();
      drive(1'b0, 1'b0, 16'h0);
   endtask

   task automatic test_clear_wrap();
      logic [15:0] sb [$];
      logic [15:0] held;
      logic        e, d;
      logic [15:0] v;
      for (int i = 0; i < 24; i++) begin
         e = 1'($urandom_range(0, 1));
         d = 1'($urandom_range(0, 1));
         v = 16'($urandom);
         drive(e, d, v);
         if (d && sb.size() > 0 && !(e && sb.size() == 3)) begin
            void'(sb.pop_front());
            if (e) sb.push_back(v);
         end else if (e && sb.size() < 3) begin
            sb.push_back(v);
         end else if (d && sb.size() > 0) begin
            void'(sb.pop_front());
         end
         tick();
         tests++;
         if (bus.EMPTY_N !== (sb.size() != 0) ||
             bus.FULL_N !== (sb.size() != 3) ||
             (sb.size() != 0 && bus.D_OUT !== sb[0])) begin
            fails++;
            $display("FAIL wrap i=%0d got=%b%b/%h exp_size=%0d exp_head=%h",
                     i, bus.EMPTY_N, bus.FULL_N, bus.D_OUT, sb.size(),
                     (sb.size() != 0) ? sb[0] : 16'h0);
         end
      end
      held = bus.D_OUT;
      drive(1'b1, 1'b0, 16'h1234);
      bus.CLR = 1'b1;
      tick();
      bus.CLR = 1'b0;
      drive(1'b0, 1'b0, 16'h0);
      tests++;
      if (bus.EMPTY_N !== 1'b0 || bus.FULL_N !== 1'b1 || bus.D_OUT !== held) begin
         fails++;
         $display("FAIL clr got=%b%b/%h exp=01/%h",
                  bus.EMPTY_N, bus.FULL_N, bus.D_OUT, held);
      end
      tick();
      tests++;
      if (bus.EMPTY_N !== 1'b0) begin
         fails++; $display("FAIL clr_enq_dropped got=%b exp=0", bus.EMPTY_N);
      end
      drive(1'b1, 1'b0, 16'h0077); tick();
      drive(1'b1, 1'b0, 16'h0078); tick();
      drive(1'b1, 1'b0, 16'h0079); tick();
      tests++;
      if (bus.D_OUT !== 16'h0077 || bus.FULL_N !== 1'b0) begin
         fails++;
         $display("FAIL clr_refill got=%h/%b exp=0077/0", bus.D_OUT, bus.FULL_N);
      end
      drive(1'b0, 1'b1, 16'h0); tick();
      tests++;
      if (bus.D_OUT !== 16'h0078) begin
         fails++; $display("FAIL clr_order1 got=%h exp=0078", bus.D_OUT);
      end
      tick();
      tests++;
      if (bus.D_OUT !== 16'h0079) begin
         fails++; $display("FAIL clr_order2 got=%h exp=0079", bus.D_OUT);
      end
      tick();
      drive(1'b0, 1'b0, 16'h0);
      tests++;
      if (bus.EMPTY_N !== 1'b0) begin
         fails++; $display("FAIL clr_final got=%b exp=0", bus.EMPTY_N);
      end
   endtask

   initial begin
      bus.CLR = 1'b0;
      drive(1'b0, 1'b0, 16'h0);
      test_reset();
      test_fill_drain();
      test_streaming();
      test_full_boundary();
      test_empty_boundary();
      test_clear_wrap();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
